pe_dbuf: RTL and testbench

//  Parametrised systolic-array processing element for the matrix multiply unit.
//  - Computes maccout = sumin + datain*weight and passes datain right, sums down.
//  - Double-buffered weights: a shadow weight is shifted in down the column while the live weight keeps computing.
//  - A swap tag travelling with the data promotes shadow to live, so weight reloads cause no bubbles.
//  - Adds optional saturating accumulation and a sticky overflow flag.

---
 rtl/pe_dbuf.sv | 87 ++++++++
 tb/tb_pe_dbuf.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pe_dbuf.sv
// Systolic-array processing element. The weights are double-buffered: a shadow weight
// shifts down the column while the live weight computes, and a swap tag promotes shadow to live.
module pe_dbuf #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int SATURATE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     active,
  input  logic signed [DATA_W-1:0] datain,
  input  logic signed [ACC_W-1:0]  sumin,
  input  logic                     swap,
  input  logic signed [DATA_W-1:0] win,
  input  logic                     wwrite,
  output logic signed [ACC_W-1:0]  maccout,
  output logic signed [DATA_W-1:0] dataout,
  output logic                     activeout,
  output logic                     swapout,
  output logic signed [DATA_W-1:0] wout,
  output logic                     wwriteout,
  output logic                     ovf
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [DATA_W-1:0]   live_w;
  logic signed [DATA_W-1:0]   shadow_w;
  logic signed [DATA_W-1:0]   eff_w;
  logic signed [2*DATA_W-1:0] prod;
  logic        [ACC_W:0]      sum;
  logic                       sum_ovf;
  logic        [ACC_W-1:0]    sum_res;

  // The swap-tagged operand already computes with the promoted (pre-write) shadow weight.
  always_comb begin
    eff_w   = swap ? shadow_w : live_w;
    prod    = (2*DATA_W)'(datain) * (2*DATA_W)'(eff_w);
    sum     = {sumin[ACC_W-1], sumin}
            + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
    sum_res = sum[ACC_W-1:0];
    if (SATURATE != 0 && sum_ovf)
      sum_res = sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  // The weight shift chain runs independently of active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_w  <= '0;
      wout      <= '0;
      wwriteout <= 1'b0;
    end else if (wwrite) begin
      shadow_w  <= win;
      wout      <= shadow_w;
      wwriteout <= 1'b1;
    end else begin
      wout      <= '0;
      wwriteout <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_w    <= '0;
      maccout   <= '0;
      dataout   <= '0;
      activeout <= 1'b0;
      swapout   <= 1'b0;
      ovf       <= 1'b0;
    end else if (active) begin
      if (swap)
        live_w <= shadow_w;
      maccout   <= sum_res;
      dataout   <= datain;
      activeout <= 1'b1;
      swapout   <= swap;
      if (sum_ovf)
        ovf <= 1'b1;
    end else begin
      activeout <= 1'b0;
      swapout   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_dbuf.sv
// Bench for pe_dbuf: a wrapping and a saturating instance, with directed and random steps
// checked against an integer-arithmetic reference model.
module tb_pe_dbuf;

  logic              clk = 1'b0;
  logic              rst;
  logic              active;
  logic        [7:0] datain;
  logic        [15:0] sumin;
  logic              swap;
  logic        [7:0] win;
  logic              wwrite;

  logic [15:0] maccout0, maccout1;
  logic [7:0]  dataout0, dataout1, wout0, wout1;
  logic        activeout0, activeout1, swapout0, swapout1;
  logic        wwriteout0, wwriteout1, ovf0, ovf1;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_live, m_shadow;
  logic [15:0] m_macc0, m_macc1;
  logic [7:0]  m_data, m_wout;
  logic        m_act, m_swp, m_ww, m_ovf0, m_ovf1;

  always #5 clk = ~clk;

  pe_dbuf #(.DATA_W(8), .ACC_W(16), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .active(active), .datain(datain), .sumin(sumin),
    .swap(swap), .win(win), .wwrite(wwrite),
    .maccout(maccout0), .dataout(dataout0), .activeout(activeout0),
    .swapout(swapout0), .wout(wout0), .wwriteout(wwriteout0), .ovf(ovf0));

  pe_dbuf #(.DATA_W(8), .ACC_W(16), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .active(active), .datain(datain), .sumin(sumin),
    .swap(swap), .win(win), .wwrite(wwrite),
    .maccout(maccout1), .dataout(dataout1), .activeout(activeout1),
    .swapout(swapout1), .wout(wout1), .wwriteout(wwriteout1), .ovf(ovf1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_live = 0; m_shadow = 0;
    m_macc0 = '0; m_macc1 = '0; m_data = '0; m_wout = '0;
    m_act = 0; m_swp = 0; m_ww = 0; m_ovf0 = 0; m_ovf1 = 0;
  endtask

  task automatic check_all();
    chk("maccout_wrap", {16'd0, maccout0}, {16'd0, m_macc0});
    chk("maccout_sat",  {16'd0, maccout1}, {16'd0, m_macc1});
    chk("dataout", {24'd0, dataout0}, {24'd0, m_data});
    chk("dataout_sat", {24'd0, dataout1}, {24'd0, m_data});
    chk("activeout", {31'd0, activeout0}, {31'd0, m_act});
    chk("activeout_sat", {31'd0, activeout1}, {31'd0, m_act});
    chk("swapout", {31'd0, swapout0}, {31'd0, m_swp});
    chk("swapout_sat", {31'd0, swapout1}, {31'd0, m_swp});
    chk("wout", {24'd0, wout0}, {24'd0, m_wout});
    chk("wout_sat", {24'd0, wout1}, {24'd0, m_wout});
    chk("wwriteout", {31'd0, wwriteout0}, {31'd0, m_ww});
    chk("wwriteout_sat", {31'd0, wwriteout1}, {31'd0, m_ww});
    chk("ovf_wrap", {31'd0, ovf0}, {31'd0, m_ovf0});
    chk("ovf_sat", {31'd0, ovf1}, {31'd0, m_ovf1});
  endtask

  // One clock: drive inputs, advance the model by the spec rules, check after the edge.
  task automatic step(input logic a, input int d, input int s, input logic sw,
                      input logic ww, input int wi);
    int old_shadow, w, acc;
    active = a; datain = 8'(d); sumin = 16'(s); swap = sw; wwrite = ww; win = 8'(wi);
    @(posedge clk);
    old_shadow = m_shadow;
    if (ww) begin
      m_wout = 8'(old_shadow); m_ww = 1'b1;
    end else begin
      m_wout = '0; m_ww = 1'b0;
    end
    if (a) begin
      w = sw ? old_shadow : m_live;
      if (sw) m_live = old_shadow;
      acc = int'($signed(sumin)) + int'($signed(datain)) * w;
      m_macc0 = 16'(acc);
      if (acc > 32767)       m_macc1 = 16'h7fff;
      else if (acc < -32768) m_macc1 = 16'h8000;
      else                   m_macc1 = 16'(acc);
      if (acc > 32767 || acc < -32768) begin
        m_ovf0 = 1'b1; m_ovf1 = 1'b1;
      end
      m_data = datain; m_act = 1'b1; m_swp = sw;
    end else begin
      m_act = 1'b0; m_swp = 1'b0;
    end
    if (ww) m_shadow = int'($signed(win));
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; active = 0; datain = 0; sumin = 0; swap = 0; win = 0; wwrite = 0;
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    // chain: 5, -3, 7 then idle
    step(0, 0, 0, 0, 1, 5);
    chk("chain_wout0", {24'd0, wout0}, 32'h0);
    step(0, 0, 0, 0, 1, -3);
    chk("chain_wout1", {24'd0, wout0}, 32'h05);
    step(0, 0, 0, 0, 1, 7);
    chk("chain_wout2", {24'd0, wout0}, 32'hfd);
    step(0, 0, 0, 0, 0, 0);
    chk("chain_idle", {31'd0, wwriteout0}, 32'h0);

    // swap: live=2, shadow=3
    step(0, 0, 0, 0, 1, 2);
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 3);
    step(1, 4, 10, 1, 0, 0);
    chk("swap_macc22", {16'd0, maccout0}, 32'd22);
    chk("swap_tag", {31'd0, swapout0}, 32'd1);
    step(1, 1, 0, 0, 0, 0);
    chk("swap_macc3", {16'd0, maccout0}, 32'd3);

    // stall with toggling data and swap
    for (int i = 0; i < 3; i++) step(0, 17 + i, 100 * i, i[0], 0, 0);
    chk("stall_macc", {16'd0, maccout0}, 32'd3);
    step(1, 1, 0, 0, 0, 0);
    chk("stall_live", {16'd0, maccout0}, 32'd3);

    // overflow
    step(0, 0, 0, 0, 1, -128);
    step(1, -128, 32767, 1, 0, 0);
    chk("ovf_wrap_val", {16'd0, maccout0}, 32'h0000bfff);
    chk("ovf_sat_val", {16'd0, maccout1}, 32'h00007fff);
    step(1, 0, 5, 0, 0, 0);
    chk("ovf_sticky", {31'd0, ovf0 & ovf1}, 32'd1);

    // collision of write and swap
    step(0, 0, 0, 0, 1, 9);
    step(1, 1, 0, 1, 1, 4);
    chk("coll_macc", {16'd0, maccout0}, 32'd9);
    chk("coll_wout", {24'd0, wout0}, 32'd9);
    step(1, 1, 0, 0, 0, 0);
    chk("coll_live", {16'd0, maccout0}, 32'd9);
    step(1, 1, 0, 1, 0, 0);
    chk("coll_shadow", {16'd0, maccout0}, 32'd4);
    step(1, 1, 0, 1, 0, 0);
    chk("reswap_same", {16'd0, maccout0}, 32'd4);

    // asynchronous reset mid-stream
    step(1, 3, 11, 0, 1, 6);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #2;
    rst = 1'b0;
    step(1, 5, 7, 0, 0, 0);
    chk("post_reset_macc", {16'd0, maccout0}, 32'd7);

    // random traffic, with an occasional reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2; rst = 1'b1; #1; model_reset(); check_all(); #1; rst = 1'b0;
      end
      step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 65535)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
